// File: rtl/rvvi_stdin_responder.sv
// Console-input device on the RVVI data bus: host bytes queue in a FIFO, software pops them via DATA_ADDR.
// Optional receive interrupt is compiled in with `define STDIN_IRQ_EN.
module rvvi_stdin_responder #(
   parameter logic [31:0] DATA_ADDR   = 32'h0000_1000,
   parameter logic [31:0] STATUS_ADDR = 32'h0000_1004,
   parameter int          DEPTH       = 16,
   parameter logic [31:0] EOF_VALUE   = 32'hFFFF_FFFF
) (
   input  logic        Clk,
   input  logic        Resetn,
   input  logic        InValid,
   input  logic [7:0]  InData,
   output logic        InReady,
   input  logic [31:0] DAddr,
   input  logic        Drd,
   input  logic        Dwr,
   input  logic [31:0] DData,
   output logic        RdValid,
   output logic [31:0] RdData,
   output logic        RxIrq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [7:0]    drop_cnt, drop_base;
   logic          irq_en;
   logic          full, empty, push, pop, drop;
   logic          hit_data, hit_stat, wr_stat;
   logic [31:0]   status;
   logic          unused_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign InReady = !full;

   // A full FIFO drops the byte even when a pop frees a slot this cycle.
   assign push = InValid && !full;
   assign drop = InValid && full;

   assign hit_data = Drd && (DAddr == DATA_ADDR);
   assign hit_stat = Drd && (DAddr == STATUS_ADDR);
   assign wr_stat  = Dwr && (DAddr == STATUS_ADDR);
   assign pop      = hit_data && !empty;

   assign status = {drop_cnt, 8'h00, 8'(count), 5'b0, irq_en, full, empty};

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= InData;
   end

   // Clear takes effect first so a drop in the same cycle is still counted.
   assign drop_base = (wr_stat && DData[0]) ? 8'h00 : drop_cnt;

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn)                           drop_cnt <= 8'h00;
      else if (drop && drop_base != 8'hFF)   drop_cnt <= drop_base + 8'h01;
      else                                   drop_cnt <= drop_base;
   end

   // Response snapshots pre-update state; RdData holds between responses.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         RdValid <= 1'b0;
         RdData  <= 32'h0;
      end else begin
         RdValid <= hit_data || hit_stat;
         if (hit_data)      RdData <= empty ? EOF_VALUE : {24'h0, mem[rd_ptr]};
         else if (hit_stat) RdData <= status;
      end
   end

`ifdef STDIN_IRQ_EN
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         irq_en <= 1'b0;
         RxIrq  <= 1'b0;
      end else begin
         if (wr_stat) irq_en <= DData[2];
         RxIrq <= irq_en && (count_nxt != '0);
      end
   end
   assign unused_ok = ^{DData[31:3], DData[1]};
`else
   assign irq_en    = 1'b0;
   assign RxIrq     = 1'b0;
   assign unused_ok = ^DData[31:1];
`endif

endmodule

// File: tb/tb_rvvi_stdin_responder.sv
// Scoreboard bench for rvvi_stdin_responder: reads queue expected data, a negedge monitor checks responses.
module tb_rvvi_stdin_responder;

   localparam logic [31:0] DA  = 32'h0000_1000;
   localparam logic [31:0] SA  = 32'h0000_1004;
   localparam logic [31:0] EOFV = 32'hFFFF_FFFF;

   logic        Clk = 1'b0;
   logic        Resetn;
   logic        InValid;
   logic [7:0]  InData;
   logic        InReady;
   logic [31:0] DAddr;
   logic        Drd;
   logic        Dwr;
   logic [31:0] DData;
   logic        RdValid;
   logic [31:0] RdData;
   logic        RxIrq;

   int tests = 0;
   int fails = 0;
   logic [31:0] expq[$];
   logic [31:0] e;

   rvvi_stdin_responder dut (
      .Clk(Clk), .Resetn(Resetn), .InValid(InValid), .InData(InData), .InReady(InReady),
      .DAddr(DAddr), .Drd(Drd), .Dwr(Dwr), .DData(DData),
      .RdValid(RdValid), .RdData(RdData), .RxIrq(RxIrq)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   always @(negedge Clk) begin
      if (RdValid) begin
         tests++;
         if (expq.size() == 0) begin
            fails++;
            $display("FAIL rd_unexpected got=%h want=no response", RdData);
         end else begin
            e = expq.pop_front();
            if (RdData !== e) begin
               fails++;
               $display("FAIL rd_data got=%h want=%h", RdData, e);
            end
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h want=%h", n, act, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [7:0] ib, input logic rd,
                       input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic [31:0] exp);
      InValid = iv; InData = ib; Drd = rd; DAddr = a; Dwr = wr; DData = wd;
      if (rd && (a == DA || a == SA)) expq.push_back(exp);
      @(negedge Clk);
      InValid = 1'b0; InData = 8'h00; Drd = 1'b0; DAddr = 32'h0; Dwr = 1'b0; DData = 32'h0;
   endtask

   task automatic push(input logic [7:0] b);
      step(1'b1, b, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      step(1'b0, 8'h00, 1'b1, a, 1'b0, 32'h0, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 8'h00, 1'b0, a, 1'b1, d, 32'h0);
   endtask

   initial begin
      Resetn = 1'b0; InValid = 1'b0; InData = 8'h00;
      DAddr = 32'h0; Drd = 1'b0; Dwr = 1'b0; DData = 32'h0;
      #12;
      chk("reset_rdvalid", {31'h0, RdValid}, 32'h0);
      chk("reset_rddata", RdData, 32'h0);
      chk("reset_inready", {31'h0, InReady}, 32'h1);
      chk("reset_rxirq", {31'h0, RxIrq}, 32'h0);
      @(negedge Clk);
      Resetn = 1'b1;
      @(negedge Clk);

      // empty reads, and addresses that must not respond
      rd(DA, EOFV);
      rd(SA, 32'h0000_0001);
      rd(32'h0000_1008, 32'h0);
      rd(32'h8000_1000, 32'h0);
      rd(32'h0000_1001, 32'h0);

      // "Hi\n"
      push(8'h48); push(8'h69); push(8'h0A);
      rd(SA, 32'h0000_0300);
      rd(DA, 32'h0000_0048);
      rd(DA, 32'h0000_0069);
      rd(DA, 32'h0000_000A);
      rd(SA, 32'h0000_0001);

      // overflow: 18 pushes into 16 entries
      for (int i = 0; i < 18; i++) begin
         push(8'h40 + 8'(i));
         if (i == 14) chk("inready_15", {31'h0, InReady}, 32'h1);
         if (i == 15) chk("inready_full", {31'h0, InReady}, 32'h0);
      end
      // read and clear in one cycle: read sees old drop_cnt
      step(1'b0, 8'h00, 1'b1, SA, 1'b1, 32'h1, 32'h0200_1002);
      rd(SA, 32'h0000_1002);
      wr(DA, 32'h1);
      rd(SA, 32'h0000_1002);

      // full: push+pop same cycle drops the push
      step(1'b1, 8'hEE, 1'b1, DA, 1'b0, 32'h0, 32'h0000_0040);
      rd(SA, 32'h0100_0F00);
      for (int i = 1; i < 16; i++) rd(DA, 32'h40 + 32'(i));
      rd(DA, EOFV);
      wr(SA, 32'h1);

      // count 5: push+pop keeps order
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      step(1'b1, 8'h55, 1'b1, DA, 1'b0, 32'h0, 32'h0000_0050);
      rd(SA, 32'h0000_0500);
      for (int i = 1; i < 6; i++) rd(DA, 32'h50 + 32'(i));
      rd(SA, 32'h0000_0001);

      // push with empty read in same cycle
      step(1'b1, 8'h7A, 1'b1, DA, 1'b0, 32'h0, EOFV);
      rd(SA, 32'h0000_0100);
      rd(DA, 32'h0000_007A);

      // pointer wrap
      for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
      for (int i = 0; i < 16; i++) rd(DA, 32'h80 + 32'(i));
      for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 16; i++) rd(DA, 32'hA0 + 32'(i));
      rd(SA, 32'h0000_0001);

`ifdef STDIN_IRQ_EN
      wr(SA, 32'h4);
      push(8'h31);
      chk("irq_set", {31'h0, RxIrq}, 32'h1);
      rd(SA, 32'h0000_0104);
      rd(DA, 32'h0000_0031);
      chk("irq_clear", {31'h0, RxIrq}, 32'h0);
      wr(SA, 32'h0);
`else
      wr(SA, 32'h4);
      push(8'h31);
      chk("irq_absent", {31'h0, RxIrq}, 32'h0);
      rd(SA, 32'h0000_0100);
      rd(DA, 32'h0000_0031);
`endif

      // reset during a pending response
      push(8'h11); push(8'h22); push(8'h33);
      Drd = 1'b1; DAddr = DA;
      @(posedge Clk);
      #1;
      Resetn = 1'b0; Drd = 1'b0; DAddr = 32'h0;
      #1;
      chk("rst_mid_rdvalid", {31'h0, RdValid}, 32'h0);
      chk("rst_mid_rddata", RdData, 32'h0);
      @(negedge Clk);
      Resetn = 1'b1;
      @(negedge Clk);
      chk("rst_mid_inready", {31'h0, InReady}, 32'h1);
      rd(SA, 32'h0000_0001);
      rd(DA, EOFV);

      repeat (3) @(negedge Clk);
      chk("queue_drained", 32'(expq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
